alu_share_arbiter: RTL and testbench

//   Shares one ALU instance between two requesters (req0 = execute datapath, req1 = address/branch helper).

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_share_arbiter_rr_arb2.sv | 18 +
 rtl/alu_share_arbiter.sv | 150 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALUControl encodings, arbiter FSM states and code-legality helper.
package alu_pkg;

  localparam int unsigned CTRL_W = 4;
  localparam int unsigned ST_W   = 2;

  localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b0101;
  localparam logic [CTRL_W-1:0] ALU_XOR  = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_SLTU = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_SLL  = 4'b1000;
  localparam logic [CTRL_W-1:0] ALU_SRL  = 4'b1001;
  localparam logic [CTRL_W-1:0] ALU_SRA  = 4'b1010;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_EXEC = 2'd1;
  localparam logic [ST_W-1:0] ST_RESP = 2'd2;

  // True for codes the external ALU implements.
  function automatic logic alu_ctrl_legal(input logic [CTRL_W-1:0] ctrl);
    case (ctrl)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT,
      ALU_XOR, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA: alu_ctrl_legal = 1'b1;
      default:                                      alu_ctrl_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: ptr picks the winner only when both request.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant,
  output logic       grant_id
);

  // Winner selection and one-hot grant.
  always_comb begin
    grant    = 2'b00;
    grant_id = (valid == 2'b11) ? ptr : valid[1];
    if (|valid) begin
      grant[grant_id] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external ALU between two requesters: round-robin grant, operand
// latch, one-cycle execute, then a held response until the consumer takes it.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [3:0]        req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [3:0]        req1_ctrl,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [3:0]        alu_ctrl,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [WIDTH-1:0]  rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err
);

  logic [ST_W-1:0]   state_q, state_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]  op_a_q, op_a_d;
  logic [WIDTH-1:0]  op_b_q, op_b_d;
  logic [3:0]        op_ctrl_q, op_ctrl_d;
  logic              op_err_q, op_err_d;
  logic              op_id_q, op_id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]  rsp_result_q, rsp_result_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              rsp_err_q, rsp_err_d;

  logic [1:0]        grant;
  logic              grant_id;
  logic [3:0]        sel_ctrl;

  rr_arb2 u_arb (
    .valid    ({req1_valid, req0_valid}),
    .ptr      (rr_ptr_q),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Next-state, operand latch and response capture; ready is combinational in IDLE.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_ctrl_d    = op_ctrl_q;
    op_err_d     = op_err_q;
    op_id_d      = op_id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    sel_ctrl     = grant_id ? req1_ctrl : req0_ctrl;

    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          req0_ready = grant[0] & ~reset;
          req1_ready = grant[1] & ~reset;
          op_a_d     = grant_id ? req1_a : req0_a;
          op_b_d     = grant_id ? req1_b : req0_b;
          op_err_d   = ~alu_ctrl_legal(sel_ctrl);
          op_ctrl_d  = alu_ctrl_legal(sel_ctrl) ? sel_ctrl : ALU_ADD;
          op_id_d    = grant_id;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_valid_d  = 1'b1;
        rsp_id_d     = op_id_q;
        rsp_result_d = op_err_q ? '0 : alu_result;
        rsp_zero_d   = op_err_q | alu_zero;
        rsp_err_d    = op_err_q;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = ~rsp_id_q;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset discarding any in-flight op.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_ctrl_q    <= ALU_ADD;
      op_err_q     <= 1'b0;
      op_id_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_ctrl_q    <= op_ctrl_d;
      op_err_q     <= op_err_d;
      op_id_q      <= op_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign alu_a      = op_a_q;
  assign alu_b      = op_b_q;
  assign alu_ctrl   = op_ctrl_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios, then a randomized run
// against a transaction-level model; the external ALU is modelled here too.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, rsp_ready;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_ctrl;
  logic        alu_zero;
  logic        rsp_valid, rsp_id, rsp_zero, rsp_err;
  logic [31:0] rsp_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    logic signed [31:0] sa;
    sa = a;
    case (c)
      4'd0:    alu_fn = a + b;
      4'd1:    alu_fn = a - b;
      4'd2:    alu_fn = a & b;
      4'd3:    alu_fn = a | b;
      4'd5:    alu_fn = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:    alu_fn = a ^ b;
      4'd7:    alu_fn = (a < b) ? 32'd1 : 32'd0;
      4'd8:    alu_fn = a << b[4:0];
      4'd9:    alu_fn = a >> b[4:0];
      4'd10:   alu_fn = 32'(sa >>> b[4:0]);
      default: alu_fn = 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic legal_code(input logic [3:0] c);
    legal_code = (c <= 4'd3) || (c >= 4'd5 && c <= 4'd10);
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_ctrl);
  assign alu_zero   = (alu_result == 32'd0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Random-phase model state.
  int          phase;
  logic        pref, win, taken;
  logic        e_id, e_zero, e_err;
  logic [31:0] e_res;

  initial begin
    reset = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = '0; req0_b = '0; req0_ctrl = '0;
    req1_a = '0; req1_b = '0; req1_ctrl = '0;
    step(); step();
    chk1("rst_ready0", req0_ready, 1'b0);
    chk1("rst_ready1", req1_ready, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_rsp_id", rsp_id, 1'b0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk1("rst_rsp_zero", rsp_zero, 1'b0);
    chk1("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    step();

    // Single op: 5 - 3 from requester 0.
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_ctrl = 4'b0001;
    #1;
    chk1("single_ready0", req0_ready, 1'b1);
    chk1("single_ready1", req1_ready, 1'b0);
    step();
    req0_valid = 1'b0; #1;
    chk1("exec_ready0", req0_ready, 1'b0);
    chk1("exec_rsp_valid", rsp_valid, 1'b0);
    chk("exec_alu_a", alu_a, 32'd5);
    chk("exec_alu_b", alu_b, 32'd3);
    chk("exec_alu_ctrl", 32'(alu_ctrl), 32'd1);
    step();
    chk1("single_rsp_valid", rsp_valid, 1'b1);
    chk1("single_rsp_id", rsp_id, 1'b0);
    chk("single_rsp_result", rsp_result, 32'd2);
    chk1("single_rsp_zero", rsp_zero, 1'b0);
    chk1("single_rsp_err", rsp_err, 1'b0);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    chk1("single_done", rsp_valid, 1'b0);

    // Contention from reset: requester 0 first, then 1.
    reset = 1'b1; step(); reset = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_ctrl = 4'b0000;
    req1_valid = 1'b1; req1_a = 32'hF0; req1_b = 32'h0F; req1_ctrl = 4'b0110;
    #1;
    chk1("cont_ready0", req0_ready, 1'b1);
    chk1("cont_ready1", req1_ready, 1'b0);
    step(); req0_valid = 1'b0;
    step();
    chk1("cont0_id", rsp_id, 1'b0);
    chk("cont0_result", rsp_result, 32'd2);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0; #1;
    chk1("cont1_ready1", req1_ready, 1'b1);
    step(); req1_valid = 1'b0;
    step();
    chk1("cont1_id", rsp_id, 1'b1);
    chk("cont1_result", rsp_result, 32'hFF);

    // Both valid again after requester 1 served -> requester 0; then backpressure.
    req0_a = 32'hFF00; req0_b = 32'h0FF0; req0_ctrl = 4'b0010;
    req1_a = 32'd7; req1_b = 32'd7; req1_ctrl = 4'b1011;
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    chk1("again_ready0", req0_ready, 1'b1);
    chk1("again_ready1", req1_ready, 1'b0);
    step(); req0_a = 32'h1234_5678;
    step();
    for (int i = 0; i < 5; i++) begin
      chk1("bp_valid", rsp_valid, 1'b1);
      chk1("bp_id", rsp_id, 1'b0);
      chk("bp_result", rsp_result, 32'h0F00);
      chk1("bp_ready0", req0_ready, 1'b0);
      chk1("bp_ready1", req1_ready, 1'b0);
      step();
    end
    req0_a = 32'hFF00;
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0; #1;

    // Illegal code from requester 1.
    chk1("ill_ready1", req1_ready, 1'b1);
    chk1("ill_ready0", req0_ready, 1'b0);
    step(); req0_valid = 1'b0; req1_valid = 1'b0; #1;
    chk("ill_alu_ctrl", 32'(alu_ctrl), 32'd0);
    chk("ill_alu_a", alu_a, 32'd7);
    step();
    chk1("ill_err", rsp_err, 1'b1);
    chk("ill_result", rsp_result, 32'd0);
    chk1("ill_zero", rsp_zero, 1'b1);
    chk1("ill_id", rsp_id, 1'b1);

    // Reset while the response is pending.
    req0_valid = 1'b1; req1_valid = 1'b1; reset = 1'b1; #1;
    chk1("rstr_ready0_in_reset", req0_ready, 1'b0);
    step(); reset = 1'b0; #1;
    chk1("rstr_rsp_valid", rsp_valid, 1'b0);
    chk1("rstr_rsp_err", rsp_err, 1'b0);
    chk1("rstr_rsp_id", rsp_id, 1'b0);
    chk("rstr_rsp_result", rsp_result, 32'd0);
    chk1("rstr_rsp_zero", rsp_zero, 1'b0);
    chk("rstr_alu_a", alu_a, 32'd0);
    chk("rstr_alu_b", alu_b, 32'd0);
    chk1("rstr_tie_ready0", req0_ready, 1'b1);
    chk1("rstr_tie_ready1", req1_ready, 1'b0);
    step(); req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    step();
    chk1("rstr_op_id", rsp_id, 1'b0);
    chk("rstr_op_result", rsp_result, 32'h0F00);
    step();

    // Streaming sra from requester 0: one response every 3 cycles.
    begin
      int last, cyc, n;
      last = -1; cyc = 0; n = 0;
      req0_valid = 1'b1; req0_a = 32'h8000_0000; req0_b = 32'd4; req0_ctrl = 4'b1010;
      for (int i = 0; i < 12; i++) begin
        step(); cyc++;
        if (rsp_valid) begin
          chk("stream_result", rsp_result, 32'hF800_0000);
          if (last >= 0) chk("stream_gap", 32'(cyc - last), 32'd3);
          last = cyc; n++;
        end
      end
      chk("stream_count", 32'(n), 32'd4);
    end
    req0_valid = 1'b0;
    repeat (4) step();

    // Zero flag on 9 - 9.
    begin
      bit got;
      req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9; req0_ctrl = 4'b0001; #1;
      chk1("sub_ready0", req0_ready, 1'b1);
      step(); req0_valid = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 5 && !got; i++) begin
        step();
        got = rsp_valid;
      end
      chk1("sub_rsp_seen", got, 1'b1);
      chk("sub_result", rsp_result, 32'd0);
      chk1("sub_zero", rsp_zero, 1'b1);
      chk1("sub_err", rsp_err, 1'b0);
      step(); step();
    end

    // Randomized traffic against the transaction-level model.
    rsp_ready = 1'b0; reset = 1'b1; step(); reset = 1'b0;
    phase = 0; pref = 1'b0;
    e_id = 1'b0; e_res = '0; e_zero = 1'b0; e_err = 1'b0;
    for (int i = 0; i < 400; i++) begin
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_a = $urandom; req0_b = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
      req1_a = $urandom; req1_b = ($urandom_range(0, 3) == 0) ? req1_a : 32'($urandom_range(0, 40));
      req0_ctrl = 4'($urandom_range(0, 15));
      req1_ctrl = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 1) == 1);
      #1;
      taken = (phase == 0) && (req0_valid || req1_valid);
      win = (req0_valid && req1_valid) ? pref : req1_valid;
      chk1("rnd_ready0", req0_ready, taken && !win);
      chk1("rnd_ready1", req1_ready, taken && win);
      chk1("rnd_rsp_valid", rsp_valid, phase == 2);
      if (phase == 2) begin
        chk1("rnd_rsp_id", rsp_id, e_id);
        chk("rnd_rsp_result", rsp_result, e_res);
        chk1("rnd_rsp_zero", rsp_zero, e_zero);
        chk1("rnd_rsp_err", rsp_err, e_err);
      end
      if (taken) begin
        logic [31:0] a, b;
        logic [3:0]  c;
        a = win ? req1_a : req0_a;
        b = win ? req1_b : req0_b;
        c = win ? req1_ctrl : req0_ctrl;
        e_id   = win;
        e_err  = !legal_code(c);
        e_res  = e_err ? 32'd0 : alu_fn(a, b, c);
        e_zero = e_err ? 1'b1 : (e_res == 32'd0);
        phase  = 1;
      end else if (phase == 1) begin
        phase = 2;
      end else if (phase == 2 && rsp_ready) begin
        phase = 0;
        pref  = !e_id;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
